mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 8:1, 32-bit mux datapath among eight requesters. Each requester offers a word with a valid/ready handshake.
- The block chooses one requester per transfer, drives the mux select, and registers the selected word into a single-entry output stage with its own valid/ready handshake.
- It sits between eight producer blocks and one downstream consumer. It replaces static software control of the mux select.

---
 rtl/mux8_rr_arbiter.sv | 94 +++++++++
 tb/tb_mux8_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter over eight valid/ready requesters feeding a shared 8:1 mux
// into a single-entry registered output stage, with optional grant holding.

module mux8_rr_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic             gnt,
  output logic [WIDTH-1:0] gated
);
  assign gated = data & {WIDTH{gnt}};
endmodule

module mux8_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int HOLD_MAX = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  output logic               busy
);
  localparam int NUM_LANES = 8;
  localparam int CW        = 5;  // holds 0..16

  logic [2:0]                          owner, gnt_idx, rot_idx;
  logic [CW-1:0]                       hold_cnt;
  logic                                load, gnt_vld, hold_take;
  logic [NUM_LANES-1:0]                gnt_oh;
  logic [NUM_LANES-1:0][WIDTH-1:0]     lane_data, lane_gated;
  logic [WIDTH-1:0]                    mux_data;

  assign lane_data = in_data;
  assign load      = ~out_valid | out_ready;
  assign hold_take = in_valid[owner] && (hold_cnt < CW'(HOLD_MAX));

  // Search owner+1 .. owner; k==8 wraps back to owner, giving it lowest priority.
  always_comb begin
    rot_idx = owner;
    for (int k = NUM_LANES; k >= 1; k--) begin
      if (in_valid[3'(owner + 3'(k))]) rot_idx = 3'(owner + 3'(k));
    end
  end

  assign gnt_idx  = hold_take ? owner : rot_idx;
  assign gnt_vld  = rst_n & load & (|in_valid);
  assign gnt_oh   = gnt_vld ? (NUM_LANES'(1) << gnt_idx) : '0;
  assign in_ready = gnt_oh;
  assign busy     = out_valid | (|in_valid);

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      mux8_rr_lane #(.WIDTH(WIDTH)) u_lane (
        .data  (lane_data[i]),
        .gnt   (gnt_oh[i]),
        .gated (lane_gated[i])
      );
    end
  endgenerate

  always_comb begin
    mux_data = '0;
    for (int j = 0; j < NUM_LANES; j++) mux_data = mux_data | lane_gated[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      owner     <= 3'd7;
      hold_cnt  <= CW'(HOLD_MAX);
    end else if (gnt_vld) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= gnt_idx;
      if (hold_take) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        owner    <= gnt_idx;
        hold_cnt <= CW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: two instances (HOLD_MAX 1 and 3) share one stimulus;
// expected words are queued when stimulus is applied and popped as the output drains.

module tb_mux8_rr_arbiter;
  localparam int W = 32;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  logic           clk, rst_n, out_ready;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     r1, r3;
  logic           ov1, ov3, b1, b3;
  logic [W-1:0]   od1, od3;
  logic [2:0]     os1, os3;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  mux8_rr_arbiter #(.WIDTH(W), .HOLD_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(r1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sel(os1), .busy(b1));

  mux8_rr_arbiter #(.WIDTH(W), .HOLD_MAX(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(r3),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_sel(os3), .busy(b3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input int s);
    q.push_back('{sel: 3'(s), data: W'(s)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ov1 !== 1'b0 || od1 !== '0 || r1 !== 8'h00 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got valid=%0b data=%0h ready=%0h busy=%0b want all 0", ov1, od1, r1, b1);
    end
    in_valid = 8'hFF; #1;
    checks++;
    if (r1 !== 8'h00) begin errors++; $display("FAIL reset_ready got %0h want 00", r1); end
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if (ov1 !== 1'b0 || od1 !== '0 || os1 !== 3'd0 || r1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_release got valid=%0b data=%0h sel=%0d ready=%0h want 0", ov1, od1, os1, r1);
    end
    @(negedge clk); #1;
    checks++;
    if (ov1 !== 1'b0 || b1 !== 1'b0) begin
      errors++; $display("FAIL reset_idle_after got valid=%0b busy=%0b want 0", ov1, b1);
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    in_valid = 8'h04; out_ready = 1'b1;
    repeat (5) push(2);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (r1 !== 8'h04) begin errors++; $display("FAIL single_ready c=%0d got %0h want 04", c, r1); end
      if (ov1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL single_extra got sel=%0d", os1); end
        else begin
          e = q.pop_front();
          if (os1 !== e.sel || od1 !== e.data) begin
            errors++;
            $display("FAIL single_word got sel=%0d data=%0h want sel=%0d data=%0h", os1, od1, e.sel, e.data);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL single_missing got %0d left want 0", q.size()); end
    q.delete(); in_valid = '0;
  endtask

  task automatic test_contention();
    exp_t e;
    int   cnt[8];
    logic ok;
    do_reset();
    in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin push(i); cnt[i] = 0; end
    push(0); push(1);
    for (int c = 0; c < 11; c++) begin
      #1;
      if (c < 8) begin
        for (int i = 0; i < 8; i++) cnt[i] += int'(r1[i]);
        checks++;
        if (r1 !== 8'(1 << c)) begin errors++; $display("FAIL rr_ready c=%0d got %0h want %0h", c, r1, 8'(1 << c)); end
      end
      if (c > 0) begin
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL rr_busy c=%0d got %0b want 1", c, b1); end
      end
      if (ov1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rr_extra got sel=%0d", os1); end
        else begin
          e = q.pop_front();
          if (os1 !== e.sel || od1 !== e.data) begin
            errors++;
            $display("FAIL rr_word got sel=%0d data=%0h want sel=%0d data=%0h", os1, od1, e.sel, e.data);
          end
        end
      end
      @(negedge clk);
    end
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (cnt[i] != 1) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_fair got %0d %0d %0d %0d %0d %0d %0d %0d want all 1",
      cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5], cnt[6], cnt[7]); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rr_missing got %0d left want 0", q.size()); end
    q.delete(); in_valid = '0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    in_valid = 8'h22; out_ready = 1'b0;
    push(1); push(5); push(1);
    #1;
    checks++;
    if (r1 !== 8'h02) begin errors++; $display("FAIL bp_first_ready got %0h want 02", r1); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (ov1 !== 1'b1 || od1 !== W'(1) || os1 !== 3'd1 || r1 !== 8'h00) begin
        errors++;
        $display("FAIL bp_hold c=%0d got valid=%0b data=%0h sel=%0d ready=%0h want 1/1/1/00", c, ov1, od1, os1, r1);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (c == 0) begin
        checks++;
        if (r1 !== 8'h20) begin errors++; $display("FAIL bp_release_ready got %0h want 20", r1); end
      end
      if (ov1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_extra got sel=%0d", os1); end
        else begin
          e = q.pop_front();
          if (os1 !== e.sel || od1 !== e.data) begin
            errors++;
            $display("FAIL bp_word got sel=%0d data=%0h want sel=%0d data=%0h", os1, od1, e.sel, e.data);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL bp_missing got %0d left want 0", q.size()); end
    q.delete(); in_valid = '0;
  endtask

  task automatic test_hold();
    exp_t e;
    do_reset();
    in_valid = 8'h09; out_ready = 1'b1;
    push(0); push(0); push(0); push(3); push(3); push(3); push(0); push(0);
    for (int c = 0; c < 9; c++) begin
      #1;
      if (ov3 && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL hold_extra got sel=%0d", os3); end
        else begin
          e = q.pop_front();
          if (os3 !== e.sel || od3 !== e.data) begin
            errors++;
            $display("FAIL hold_word got sel=%0d data=%0h want sel=%0d data=%0h", os3, od3, e.sel, e.data);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL hold_missing got %0d left want 0", q.size()); end
    q.delete();
    // Lane 0 drops out after its second grant; lane 3 must win right away.
    do_reset();
    in_valid = 8'h09; out_ready = 1'b1;
    push(0); push(0); push(3); push(3); push(3);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) in_valid = 8'h08;
      #1;
      if (c == 2) begin
        checks++;
        if (r3 !== 8'h08) begin errors++; $display("FAIL hold_drop_ready got %0h want 08", r3); end
      end
      if (ov3 && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL hold_drop_extra got sel=%0d", os3); end
        else begin
          e = q.pop_front();
          if (os3 !== e.sel || od3 !== e.data) begin
            errors++;
            $display("FAIL hold_drop_word got sel=%0d data=%0h want sel=%0d data=%0h", os3, od3, e.sel, e.data);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL hold_drop_missing got %0d left want 0", q.size()); end
    q.delete(); in_valid = '0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    in_valid = 8'hFF; out_ready = 1'b1;
    push(0); push(1);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ov1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL mid_extra got sel=%0d", os1); end
        else begin
          e = q.pop_front();
          if (os1 !== e.sel || od1 !== e.data) begin
            errors++;
            $display("FAIL mid_word got sel=%0d data=%0h want sel=%0d data=%0h", os1, od1, e.sel, e.data);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ov1 !== 1'b1 || os1 !== 3'd2) begin
      errors++; $display("FAIL mid_pre got valid=%0b sel=%0d want 1/2", ov1, os1);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (ov1 !== 1'b0 || od1 !== '0 || os1 !== 3'd0 || r1 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got valid=%0b data=%0h sel=%0d ready=%0h want 0", ov1, od1, os1, r1);
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if (r1 !== 8'h01) begin errors++; $display("FAIL mid_first_ready got %0h want 01", r1); end
    @(negedge clk); #1;
    checks++;
    if (ov1 !== 1'b1 || os1 !== 3'd0) begin
      errors++; $display("FAIL mid_first_word got valid=%0b sel=%0d want 1/0", ov1, os1);
    end
    q.delete(); in_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = W'(i);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
